// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, control-bit indices, idle control word and T-state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam int B_CP   = 14;
    localparam int B_EP   = 13;
    localparam int B_LP   = 12;
    localparam int B_NLMA = 11;
    localparam int B_NLMD = 10;
    localparam int B_NCE  = 9;
    localparam int B_NLR  = 8;
    localparam int B_NLI  = 7;
    localparam int B_NEI  = 6;
    localparam int B_NLA  = 5;
    localparam int B_EA   = 4;
    localparam int B_SUB  = 3;
    localparam int B_EU   = 2;
    localparam int B_NLB  = 1;
    localparam int B_NLO  = 0;

    // Asserting any signal flips its bit away from the idle level, so a step is CTRL_IDLE ^ mask.
    localparam logic [14:0] M_CP   = 15'(1) << B_CP;
    localparam logic [14:0] M_EP   = 15'(1) << B_EP;
    localparam logic [14:0] M_LP   = 15'(1) << B_LP;
    localparam logic [14:0] M_NLMA = 15'(1) << B_NLMA;
    localparam logic [14:0] M_NLMD = 15'(1) << B_NLMD;
    localparam logic [14:0] M_NCE  = 15'(1) << B_NCE;
    localparam logic [14:0] M_NLR  = 15'(1) << B_NLR;
    localparam logic [14:0] M_NLI  = 15'(1) << B_NLI;
    localparam logic [14:0] M_NEI  = 15'(1) << B_NEI;
    localparam logic [14:0] M_NLA  = 15'(1) << B_NLA;
    localparam logic [14:0] M_EA   = 15'(1) << B_EA;
    localparam logic [14:0] M_SUB  = 15'(1) << B_SUB;
    localparam logic [14:0] M_EU   = 15'(1) << B_EU;
    localparam logic [14:0] M_NLB  = 15'(1) << B_NLB;
    localparam logic [14:0] M_NLO  = 15'(1) << B_NLO;

    localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd7
    } tstate_t;

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational control word for the current T-state, opcode and flags.
module microcode_rom #(
    parameter logic [14:0] CTRL_IDLE = cpu_pkg::CTRL_IDLE
) (
    input  cpu_pkg::tstate_t state,
    input  logic [3:0]       opcode,
    input  logic             CF,
    input  logic             ZF,
    output logic [14:0]      word
);
    import cpu_pkg::*;

    logic [14:0] m;

    always_comb begin
        m = '0;
        case (state)
            T0: m = M_EP | M_NLMA;
            T1: m = M_CP;
            T2: m = M_NCE | M_NLI;
            T3: case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: m = M_NEI | M_NLMA;
                OP_LDI: m = M_NEI | M_NLA;
                OP_JMP: m = M_NEI | M_LP;
                OP_JC:  m = CF ? (M_NEI | M_LP) : '0;
                OP_JZ:  m = ZF ? (M_NEI | M_LP) : '0;
                OP_OUT: m = M_EA | M_NLO;
                default: m = '0;
            endcase
            T4: case (opcode)
                OP_LDA:         m = M_NCE | M_NLA;
                OP_ADD, OP_SUB: m = M_NCE | M_NLB;
                OP_STA:         m = M_EA | M_NLMD;
                default:        m = '0;
            endcase
            T5: case (opcode)
                OP_ADD:  m = M_EU | M_NLA;
                OP_SUB:  m = M_EU | M_NLA | M_SUB;
                OP_STA:  m = M_NLR;
                default: m = '0;
            endcase
            default: m = '0;
        endcase
    end

    assign word = CTRL_IDLE ^ m;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state register and next-state logic driving the microcode ROM.
module control_sequencer #(
    parameter logic [14:0] CTRL_IDLE = cpu_pkg::CTRL_IDLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        CF,
    input  logic        ZF,
    output logic [14:0] out,
    output logic [2:0]  step,
    output logic        halted
);
    import cpu_pkg::*;

    tstate_t     state, state_nxt;
    logic [14:0] rom_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T0: state_nxt = T1;
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: state_nxt = T4;
                OP_HLT:  state_nxt = HALT;
                default: state_nxt = T0;
            endcase
            T4: state_nxt = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_STA) ? T5 : T0;
            T5: state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = T0;
        endcase
    end

    microcode_rom #(.CTRL_IDLE(CTRL_IDLE)) u_rom (
        .state  (state),
        .opcode (opcode),
        .CF     (CF),
        .ZF     (ZF),
        .word   (rom_word)
    );

    // Gate with rst_n so the word goes idle the instant reset asserts, not just on the T0 it forces.
    assign out    = rst_n ? rom_word : CTRL_IDLE;
    assign step   = 3'(state);
    assign halted = (state == HALT);

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 4, instruction register upper nibble, valid from T3.
REQ-004 SHALL have ports CF and ZF, input, 1 each, ALU carry and zero flags.
REQ-005 SHALL have port out, output, 15, control word; bit map [14]Cp [13]Ep [12]Lp [11]nLma [10]nLmd [9]nCE [8]nLr [7]nLi [6]nEi [5]nLa [4]Ea [3]sub [2]Eu [1]nLb [0]nLo.
REQ-006 SHALL have port step, output, 3, current T-state index 0..5, for debug.
REQ-007 SHALL have port halted, output, 1, high once HLT executes.
REQ-008 SHALL use parameter CTRL_IDLE, default 15'h0FE3, the all-inactive control word.

Function
REQ-009 SHALL hold a T-state register T0..T5 plus a HALT state; out SHALL be a combinational decode of state, opcode and flags only, with no bus path.
REQ-010 Fetch steps SHALL be opcode-independent: T0 Ep+nLma (15'h27E3); T1 Cp (15'h4FE3); T2 nCE+nLi (15'h0D63).
REQ-011 LDA(1) SHALL be: T3 nEi+nLma; T4 nCE+nLa; then T0.
REQ-012 ADD(2) SHALL be: T3 nEi+nLma; T4 nCE+nLb; T5 Eu+nLa (15'h0FC7); then T0.
REQ-013 SUB(3) SHALL match ADD, with sub additionally asserted in T5 only (15'h0FCF).
REQ-014 STA(4) SHALL be: T3 nEi+nLma; T4 Ea+nLmd; T5 nLr; then T0.
REQ-015 LDI(5) SHALL be: T3 nEi+nLa; then T0.
REQ-016 JMP(6) SHALL be: T3 nEi+Lp (15'h1FA3); then T0.
REQ-017 JC(7) and JZ(8) SHALL assert nEi+Lp in T3 only if CF (resp. ZF) is 1 during T3, else CTRL_IDLE; then T0.
REQ-018 OUT(14) SHALL be: T3 Ea+nLo (15'h0FF2); then T0.
REQ-019 HLT(15) SHALL output CTRL_IDLE in T3 and then enter HALT; HALT SHALL output CTRL_IDLE, set halted=1 and step=7, and persist until reset.
REQ-020 NOP(0) and undefined opcodes (9-13) SHALL output CTRL_IDLE in T3; then T0.
REQ-021 Each instruction SHALL return to T0 on the clock edge ending its last listed step; no idle padding steps.
REQ-022 Flags SHALL be sampled only in T3; flag changes in other steps SHALL have no effect.
REQ-023 Opcode SHALL be ignored in T0-T2.

Reset
REQ-024 rst_n low SHALL immediately force state=T0, step=0, halted=0, and out=CTRL_IDLE regardless of clock.
REQ-025 After rst_n rises, the first rising edge SHALL execute T0; reset mid-instruction or in HALT SHALL abort it with no residual state.

Structure
REQ-026 A shared package cpu_pkg SHALL hold opcode constants, control-bit index constants, CTRL_IDLE and the T-state enumeration; all CPU blocks SHALL use it.
REQ-027 Per-step decode SHALL be a combinational sub-module microcode_rom (inputs state, opcode, CF, ZF; output 15-bit word); control_sequencer SHALL own only the state register and next-state logic.

Verification
REQ-028 Reset then 3 clocks with opcode=6 -> out sequence 27E3, 4FE3, 0D63, then T3 out=1FA3, next step=0.
REQ-029 ADD then SUB -> T5 out 0FC7 then 0FCF; each instruction 6 cycles, step returns to 0.
REQ-030 JC with CF=0 in T3 -> out=0FE3 in T3; with CF=1 -> 1FA3; CF toggled in T4-T5 of prior ADD has no effect.
REQ-031 HLT -> halted=1 after T3; out stays 0FE3 for 20 clocks; rst_n low asynchronously clears halted and step.
REQ-032 rst_n asserted mid-T4 of STA -> out=0FE3 immediately, no nLr pulse; after release, fetch restarts at T0.
REQ-033 Opcodes 9-13 -> 4-cycle instruction, T3 out=0FE3, no halt.
